// File: rtl/score_controller.sv
// Game sequencer for the seven-segment scoreboard: accumulates the run score,
// keeps the session high score, and alternates final/high score after game over.
module score_controller #(
    parameter int MAX_SCORE  = 9999,
    parameter int BONUS      = 10,
    parameter int ALT_CYCLES = 100000000,
    parameter int ALT_W      = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        point,
    input  logic        bonus,
    input  logic        collide,
    output logic [13:0] score_out,
    output logic [13:0] high_score,
    output logic        gameover,
    output logic        running,
    output logic        disp_sel
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER_SCORE,
        OVER_HIGH
    } state_t;

    localparam logic [ALT_W-1:0] ALT_LAST  = ALT_W'(ALT_CYCLES - 1);
    localparam logic [14:0]      MAX_WIDE  = 15'(MAX_SCORE);
    localparam logic [14:0]      BONUS_INC = 15'(BONUS);

    state_t            state_q;
    logic [13:0]       score_q;
    logic [13:0]       high_q;
    logic [13:0]       score_out_q;
    logic [ALT_W-1:0]  cnt_q;
    logic              gameover_q;
    logic              running_q;
    logic              disp_sel_q;

    logic [14:0]       incAmount;
    logic [14:0]       incSum;
    logic [13:0]       score_d;

    // The sum is formed one bit wider so a carry past 14 bits still clamps.
    always_comb begin
        incAmount = {14'd0, point} + (bonus ? BONUS_INC : 15'd0);
        incSum    = {1'b0, score_q} + incAmount;
        score_d   = (incSum > MAX_WIDE) ? MAX_WIDE[13:0] : incSum[13:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            score_out_q <= '0;
            cnt_q       <= '0;
            gameover_q  <= 1'b0;
            running_q   <= 1'b0;
            disp_sel_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        score_q     <= '0;
                        score_out_q <= '0;
                        running_q   <= 1'b1;
                    end
                end
                RUN: begin
                    score_q     <= score_d;
                    score_out_q <= score_d;
                    if (collide) begin
                        state_q    <= OVER_SCORE;
                        high_q     <= (score_d > high_q) ? score_d : high_q;
                        cnt_q      <= '0;
                        gameover_q <= 1'b1;
                        running_q  <= 1'b0;
                        disp_sel_q <= 1'b0;
                    end
                end
                OVER_SCORE, OVER_HIGH: begin
                    // A new run wins over a display rollover landing on the same edge.
                    if (start) begin
                        state_q     <= RUN;
                        score_q     <= '0;
                        score_out_q <= '0;
                        cnt_q       <= '0;
                        gameover_q  <= 1'b0;
                        running_q   <= 1'b1;
                        disp_sel_q  <= 1'b0;
                    end else if (cnt_q == ALT_LAST) begin
                        cnt_q <= '0;
                        if (state_q == OVER_SCORE) begin
                            state_q     <= OVER_HIGH;
                            score_out_q <= high_q;
                            disp_sel_q  <= 1'b1;
                        end else begin
                            state_q     <= OVER_SCORE;
                            score_out_q <= score_q;
                            disp_sel_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign score_out  = score_out_q;
    assign high_score = high_q;
    assign gameover   = gameover_q;
    assign running    = running_q;
    assign disp_sel   = disp_sel_q;

endmodule
